// File: rtl/adder_response_misr.sv
// rtl/adder_response_misr.sv - MISR response compactor for the adder under test, start/done handshake.
// Optional MISR_COMPARE_EN adds GOLDEN parameter and registered pass output.
module adder_response_misr #(
  parameter int                 WIDTH        = 32,
  parameter int                 NUM_PATTERNS = 256,
  parameter logic [WIDTH-1:0]   POLY         = 32'h04C11DB7,
  parameter logic [WIDTH-1:0]   SEED         = 32'h00000000
`ifdef MISR_COMPARE_EN
  ,
  parameter logic [WIDTH-1:0]   GOLDEN       = '0
`endif
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic                                   resp_valid,
  input  logic [WIDTH-1:0]                       resp_data,
  input  logic                                   resp_cout,
  output logic                                   busy,
  output logic                                   done,
  output logic [WIDTH-1:0]                       signature,
  output logic [$clog2(NUM_PATTERNS+1)-1:0]      pattern_count
`ifdef MISR_COMPARE_EN
  ,
  output logic                                   pass
`endif
);

  localparam int CW = $clog2(NUM_PATTERNS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sig_q, sig_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Galois shift with feedback, then fold in sum bits and carry-out at bit 0.
  function automatic logic [WIDTH-1:0] misr_next(input logic [WIDTH-1:0] sig,
                                                 input logic [WIDTH-1:0] data,
                                                 input logic             cout);
    logic [WIDTH-1:0] fb;
    fb = sig[WIDTH-1] ? POLY : '0;
    return {sig[WIDTH-2:0], 1'b0} ^ fb ^ data ^ {{(WIDTH-1){1'b0}}, cout};
  endfunction

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // start outranks a coincident response, which is dropped
        if (start) begin
          state_d = S_RUN;
          sig_d   = SEED;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (resp_valid) begin
          sig_d = misr_next(sig_q, resp_data, resp_cout);
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            state_d = S_DONE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        sig_d   = SEED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sig_q   <= SEED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy          = (state_q == S_RUN);
  assign done          = (state_q == S_DONE);
  assign signature     = sig_q;
  assign pattern_count = cnt_q;

`ifdef MISR_COMPARE_EN
  logic pass_q;

  // Evaluated on next-state so pass lines up with done and clears on start.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= 1'b0;
    end else begin
      pass_q <= (state_d == S_DONE) && (sig_d == GOLDEN);
    end
  end

  assign pass = pass_q;
`endif

endmodule
